// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions used by the key schedule and the cipher datapath.
//   KEY_W / NR  : AES-128 key width and number of expansion rounds.
//   state_t     : key-expander FSM states.
//   sbox()      : forward S-box lookup (also used by the SubBytes stage).
//   rcon()      : round constant by expansion round 1..10.
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int KEY_W = 128;
    localparam int NR    = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] r;
        case (round)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// -----------------------------------------------------------------------------
// aes_key_step
// One AES-128 key-schedule round, purely combinational.
//   key      : current round key (w0 = key[127:96], big-endian words)
//   rcon     : round constant byte for the round being produced
//   next_key : following round key
// -----------------------------------------------------------------------------
module aes_key_step
    import aes_pkg::*;
(
    input  logic [KEY_W-1:0] key,
    input  logic [7:0]       rcon,
    output logic [KEY_W-1:0] next_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, temp;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = key;

    // RotWord: cyclic left rotate by one byte.
    assign rot = {w3[23:0], w3[31:24]};

    assign temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
                ^ {rcon, 24'h0};

    // Each new word chains on the one just produced.
    assign n0 = w0 ^ temp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_expander.sv
// -----------------------------------------------------------------------------
// aes_key_expander
// Sequential AES-128 key expansion: one round per clock into an 11-entry
// round-key buffer, with a registered read port for the cipher datapath.
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin expansion of ip_key (honoured in IDLE or READY)
//   ip_key     : cipher key, captured on the accepted start cycle
//   busy       : expansion in progress
//   key_ready  : all 11 round keys valid
//   rd_en      : read strobe
//   rd_round   : round index to read, 0..10
//   rd_key     : registered round key (zero on an invalid read)
//   rd_valid   : qualifies rd_key, one cycle after rd_en
// -----------------------------------------------------------------------------
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int NR    = aes_pkg::NR,
    parameter int KEY_W = aes_pkg::KEY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] ip_key,
    output logic             busy,
    output logic             key_ready,
    input  logic             rd_en,
    input  logic [3:0]       rd_round,
    output logic [KEY_W-1:0] rd_key,
    output logic             rd_valid
);

    if (NR != 10 || KEY_W != 128) begin : g_bad_cfg
        $error("aes_key_expander supports only AES-128 (NR=10, KEY_W=128)");
    end

    state_t           state;
    logic [3:0]       cnt;
    logic [KEY_W-1:0] work;
    logic [KEY_W-1:0] next_key;
    logic [KEY_W-1:0] key_buf [0:10];
    logic             load;

    // A start is honoured in every state except EXPAND.
    assign load = start && (state != EXPAND);

    aes_key_step u_step (
        .key      (work),
        .rcon     (rcon(cnt)),
        .next_key (next_key)
    );

    // NOTE: the buffer and work register are datapath storage with no reset;
    // their contents are only exposed once key_ready is set.
    always_ff @(posedge clk) begin
        if (load) begin
            key_buf[0] <= ip_key;
            work       <= ip_key;
        end else if (state == EXPAND) begin
            key_buf[cnt] <= next_key;
            work         <= next_key;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values (e.g. a read racing a restart sees the
    // old key_ready and the old buffer entry).
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            busy      <= 1'b0;
            key_ready <= 1'b0;
            rd_key    <= '0;
            rd_valid  <= 1'b0;
        end else begin
            if (rd_en) begin
                if (key_ready && rd_round <= 4'd10) begin
                    rd_valid <= 1'b1;
                    rd_key   <= key_buf[rd_round];
                end else begin
                    rd_valid <= 1'b0;
                    rd_key   <= '0;
                end
            end else begin
                rd_valid <= 1'b0;
            end

            case (state)
                IDLE, READY: begin
                    if (start) begin
                        cnt       <= 4'd1;
                        busy      <= 1'b1;
                        key_ready <= 1'b0;
                        state     <= EXPAND;
                    end
                end
                EXPAND: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(NR)) begin
                        busy      <= 1'b0;
                        key_ready <= 1'b1;
                        state     <= READY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_expander.sv
// -----------------------------------------------------------------------------
// tb_aes_key_expander
// Self-checking bench. The reference derives the S-box from GF(2^8) inversion
// plus the affine map and expands keys word-by-word as in FIPS-197; a cycle
// model tracks busy/key_ready/read behaviour and one process compares every
// cycle. Literal vectors pin the reference itself.
// -----------------------------------------------------------------------------
module tb_aes_key_expander;

    typedef logic [127:0] ks_t [0:10];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] ip_key = '0;
    logic         rd_en = 1'b0;
    logic [3:0]   rd_round = '0;
    logic         busy, key_ready, rd_valid;
    logic [127:0] rd_key;

    always #5 clk = ~clk;

    aes_key_expander dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ip_key    (ip_key),
        .busy      (busy),
        .key_ready (key_ready),
        .rd_en     (rd_en),
        .rd_round  (rd_round),
        .rd_key    (rd_key),
        .rd_valid  (rd_valid)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;
    int bcount = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    logic [7:0] sb [0:255];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                  ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    task automatic expand(input logic [127:0] key, output ks_t ks);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- cycle model ----------------
    bit           m_busy = 1'b0, m_ready = 1'b0, m_rd_valid = 1'b0;
    logic [127:0] m_rd_key = '0;
    int           m_left = 0;
    ks_t          m_keys, m_pending;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_ready = 1'b0; m_rd_valid = 1'b0; m_rd_key = '0; m_left = 0;
        end else begin
            if (rd_en) begin
                if (m_ready && rd_round <= 4'd10) begin
                    m_rd_valid = 1'b1; m_rd_key = m_keys[rd_round];
                end else begin
                    m_rd_valid = 1'b0; m_rd_key = '0;
                end
            end else begin
                m_rd_valid = 1'b0;
            end
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0; m_ready = 1'b1; m_keys = m_pending;
                end
            end else if (start) begin
                m_busy = 1'b1; m_ready = 1'b0; m_left = 10;
                expand(ip_key, m_pending);
            end
        end
    end

    always @(negedge clk) begin
        if (busy === 1'b1) bcount++;
        if (cmp_on) begin
            check("busy",      128'(busy),      128'(m_busy));
            check("key_ready", 128'(key_ready), 128'(m_ready));
            check("rd_valid",  128'(rd_valid),  128'(m_rd_valid));
            check("rd_key",    rd_key,          m_rd_key);
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [3:0] r);
        rd_en = 1'b1; rd_round = r;
        step();
        rd_en = 1'b0;
    endtask

    task automatic read_expect(input string name, input logic [3:0] r,
                               input logic v, input logic [127:0] k);
        do_read(r);
        check({name, "_valid"}, 128'(rd_valid), 128'(v));
        check({name, "_key"}, rd_key, k);
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 20 && key_ready !== 1'b1; i++) step();
        check({name, "_ready_timeout"}, 128'(key_ready), 128'(1'b1));
    endtask

    initial begin
        ks_t ks;
        build_sbox();
        check("model_sbox_00", 128'(sb[8'h00]), 128'(8'h63));
        check("model_sbox_53", 128'(sb[8'h53]), 128'(8'hed));
        expand(FIPS_KEY, ks);
        check("model_fips_r1",  ks[1],  FIPS_R1);
        check("model_fips_r10", ks[10], FIPS_R10);
        expand('0, ks);
        check("model_zero_r1",  ks[1],  ZERO_R1);
        check("model_zero_r10", ks[10], ZERO_R10);

        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        cmp_on = 1'b1;
        check("reset_busy",  128'(busy),      128'(1'b0));
        check("reset_ready", 128'(key_ready), 128'(1'b0));
        read_expect("idle_read", 4'd3, 1'b0, '0);

        // FIPS key, start held high with other keys during expansion.
        bcount = 0;
        ip_key = FIPS_KEY; start = 1'b1;
        step();
        for (int i = 0; i < 9; i++) begin
            ip_key = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        start = 1'b0;
        wait_ready("fips");
        check("fips_busy_cycles", 128'(bcount), 128'(10));
        for (int r = 0; r < 11; r++) do_read(4'(r));
        read_expect("fips_r0",  4'd0,  1'b1, FIPS_KEY);
        read_expect("fips_r1",  4'd1,  1'b1, FIPS_R1);
        read_expect("fips_r10", 4'd10, 1'b1, FIPS_R10);
        read_expect("oor_11",   4'd11, 1'b0, '0);
        read_expect("oor_15",   4'd15, 1'b0, '0);

        // Restart from READY with the zero key, reading on the restart cycle.
        rd_en = 1'b1; rd_round = 4'd1; ip_key = '0; start = 1'b1;
        step();
        start = 1'b0;
        check("restart_ready_drop", 128'(key_ready), 128'(1'b0));
        check("restart_same_cycle_valid", 128'(rd_valid), 128'(1'b1));
        check("restart_same_cycle_key", rd_key, FIPS_R1);
        for (int i = 0; i < 8; i++) begin
            rd_round = 4'($urandom_range(0, 10));
            step();
            check("restart_inflight_valid", 128'(rd_valid), 128'(1'b0));
        end
        rd_en = 1'b0;
        wait_ready("zero");
        read_expect("zero_r1",  4'd1,  1'b1, ZERO_R1);
        read_expect("zero_r10", 4'd10, 1'b1, ZERO_R10);

        // Reset in the middle of an expansion.
        ip_key = {$urandom, $urandom, $urandom, $urandom}; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_busy",  128'(busy),      128'(1'b0));
        check("midrst_ready", 128'(key_ready), 128'(1'b0));
        read_expect("midrst_r3", 4'd3, 1'b0, '0);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            start    = ($urandom_range(0, 7) == 0);
            ip_key   = {$urandom, $urandom, $urandom, $urandom};
            rd_en    = $urandom_range(0, 1) == 1;
            rd_round = 4'($urandom_range(0, 15));
            rst      = ($urandom_range(0, 99) == 0);
            step();
        end
        start = 1'b0; rd_en = 1'b0; rst = 1'b0;
        repeat (3) step();

        cmp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
